ethernet_rx_drain_master: RTL and testbench
===========================================

// Module: ethernet_rx_drain_master
// PURPOSE
// - MMIO initiator that drives the ethernet controller's register port and
//   empties received frames without processor involvement.
// - On rx_interrupt_pending_i: read frame size, read frame words in order,
//   stream them out valid/ready, then write the RX ack register.
// - Sits between the controller's addr/read/write port and a DMA/stream sink.
// PARAMETERS
// - data_width_p        32     MMIO and stream word width (32 or 64)
// - rx_size_addr_p      14'h0  register holding RX frame length in bytes (bits [15:0])
// - rx_data_base_p      14'h1000  byte address of RX frame buffer word 0
// - rx_ack_addr_p       14'h4  write 1 here to release the RX buffer
// - max_frame_bytes_p   1522   sizes above this are dropped
// PORTS
// - clk_i                   in   1    sole clock
// - reset_n_i               in   1    async assert, active-low reset
// - enable_i                in   1    1 = may start a new frame
// - addr_o                  out  14   MMIO byte address
// - write_en_o              out  1    MMIO write strobe, 1 cycle
// - read_en_o               out  1    MMIO read strobe, 1 cycle
// - op_size_o               out  BSG_WIDTH(SAFE_CLOG2(data_width_p/8))  always log2(data_width_p/8)
// - write_data_o            out  data_width_p  MMIO write data
// - read_data_i             in   data_width_p  sync read: valid the cycle after read_en_o
// - rx_interrupt_pending_i  in   1    frame waiting in controller
// - data_o                  out  data_width_p  stream word, byte 0 in bits [7:0]
// - v_o / ready_i           out/in 1  stream handshake
// - last_o                  out  1    final word of frame (valid with v_o)
// - last_bytes_o            out  clog2(data_width_p/8)+1  valid bytes in last word (1..B)
// - drop_o                  out  1    1-cycle pulse: frame discarded (bad size)
// - busy_o                  out  1    state != IDLE
// BEHAVIOUR
// - Reset (async on reset_n_i low): state IDLE; every output 0; counters 0;
//   takes effect immediately, even mid-frame; no ack is issued for aborted frame.
// - B = data_width_p/8. At most one MMIO strobe per cycle; never read+write together.
// - IDLE: if enable_i & rx_interrupt_pending_i -> RD_SIZE.
// - RD_SIZE: read_en_o=1, addr_o=rx_size_addr_p, 1 cycle -> CAP_SIZE.
// - CAP_SIZE: size=read_data_i[15:0]; words=ceil(size/B); idx=0.
//   size==0 or size>max_frame_bytes_p -> drop_o=1 this cycle, -> ACK; else -> RD_DATA.
// - RD_DATA: read_en_o=1, addr_o=rx_data_base_p+idx*B (mod 2^14) -> CAP_DATA.
// - CAP_DATA: register read_data_i into data_o; v_o=1 from next cycle -> STREAM.
// - STREAM: v_o=1; data_o/last_o/last_bytes_o held stable until ready_i.
//   last_o=(idx==words-1); last_bytes_o=(size%B==0)?B:size%B when last, else B.
//   On v_o&ready_i: v_o drops next cycle; last -> ACK, else idx++ -> RD_DATA.
// - ACK: write_en_o=1, addr_o=rx_ack_addr_p, write_data_o=1, 1 cycle -> HOLD.
// - HOLD: 2 cycles ignoring rx_interrupt_pending_i (controller clear latency) -> IDLE.
// - Throughput 1 word / 3 cycles with ready_i high; size read adds 2 cycles.
// - enable_i low mid-frame: frame completes; only new starts are blocked.
// - rx_interrupt_pending_i dropping mid-frame: ignored; frame completes and is acked.
// - ready_i high with v_o low: no effect. Stream never issues v_o outside STREAM.
// - addr_o/write_data_o are 0 whenever neither strobe is asserted.
// TESTING
// - 60-byte frame, B=4, ready_i=1 -> 15 words in order, last_o on word 15,
//   last_bytes_o=4, one ack write to rx_ack_addr_p, busy_o low 2 cycles after ack.
// - 61-byte frame -> 16 words, last_bytes_o=1; word 15 read from base+60.
// - size=0 and size=2000 -> drop_o pulse, no v_o, exactly one ack write.
// - ready_i low 10 cycles on word 3 -> data_o/last_o stable, no extra read_en_o.
// - reset_n_i low during word 7 -> all outputs 0 same cycle; after release with
//   pending still high, new frame starts with size read; no ack for aborted one.
// - enable_i=0 with pending high -> no strobes; enable_i 0 mid-frame -> frame completes.

Source files
------------

// File: rtl/ethernet_rx_drain_master.sv
// RX drain master: reads frame size and words over MMIO,
// streams them out valid/ready, then acks the controller.
module ethernet_rx_drain_master #(
  parameter int          data_width_p      = 32,
  parameter logic [13:0] rx_size_addr_p    = 14'h0,
  parameter logic [13:0] rx_data_base_p    = 14'h1000,
  parameter logic [13:0] rx_ack_addr_p     = 14'h4,
  parameter int          max_frame_bytes_p = 1522,
  localparam int b_lp    = data_width_p / 8,
  localparam int lg_b_lp = $clog2(b_lp),
  localparam int op_w_lp = $clog2(lg_b_lp + 1),
  localparam int lb_w_lp = lg_b_lp + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  output logic [13:0]             addr_o,
  output logic                    write_en_o,
  output logic                    read_en_o,
  output logic [op_w_lp-1:0]      op_size_o,
  output logic [data_width_p-1:0] write_data_o,
  input  logic [data_width_p-1:0] read_data_i,
  input  logic                    rx_interrupt_pending_i,
  output logic [data_width_p-1:0] data_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic [lb_w_lp-1:0]      last_bytes_o,
  output logic                    drop_o,
  output logic                    busy_o
);

  typedef enum logic [2:0] {
    IDLE, RD_SIZE, CAP_SIZE, RD_DATA,
    CAP_DATA, STREAM, ACK, HOLD
  } state_e;

  state_e state_q, state_d;

  logic [15:0]             size_q;
  logic [15:0]             words_q;
  logic [15:0]             idx_q;
  logic                    hold_q;
  logic [data_width_p-1:0] data_q;

  logic [15:0]        size_in;
  logic               size_bad;
  logic               is_last;
  logic [lg_b_lp-1:0] rem;
  logic [13:0]        data_addr;

  assign size_in   = read_data_i[15:0];
  assign size_bad  = (size_in == 16'd0)
                  || (32'(size_in) > max_frame_bytes_p);
  assign is_last   = (idx_q == words_q - 16'd1);
  assign rem       = size_q[lg_b_lp-1:0];
  assign data_addr = rx_data_base_p + 14'(idx_q * b_lp);

  assign op_size_o    = op_w_lp'(lg_b_lp);
  assign busy_o       = (state_q != IDLE);
  assign data_o       = data_q;
  assign v_o          = (state_q == STREAM);
  assign last_o       = v_o & is_last;
  assign last_bytes_o = !v_o ? '0
                      : (is_last && rem != '0) ? {1'b0, rem}
                      : lb_w_lp'(b_lp);

  // next-state and MMIO strobe decode
  always_comb begin
    state_d      = state_q;
    read_en_o    = 1'b0;
    write_en_o   = 1'b0;
    addr_o       = '0;
    write_data_o = '0;
    drop_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && rx_interrupt_pending_i)
          state_d = RD_SIZE;
      end
      RD_SIZE: begin
        read_en_o = 1'b1;
        addr_o    = rx_size_addr_p;
        state_d   = CAP_SIZE;
      end
      CAP_SIZE: begin
        if (size_bad) begin
          drop_o  = 1'b1;
          state_d = ACK;
        end else begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        read_en_o = 1'b1;
        addr_o    = data_addr;
        state_d   = CAP_DATA;
      end
      CAP_DATA: state_d = STREAM;
      STREAM: begin
        if (ready_i)
          state_d = is_last ? ACK : RD_DATA;
      end
      ACK: begin
        write_en_o   = 1'b1;
        addr_o       = rx_ack_addr_p;
        write_data_o = data_width_p'(1);
        state_d      = HOLD;
      end
      HOLD: begin
        if (hold_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, frame counters and captured stream word
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      size_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      hold_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        CAP_SIZE: begin
          size_q  <= size_in;
          words_q <= 16'((17'(size_in) + 17'(b_lp - 1)) >> lg_b_lp);
          idx_q   <= '0;
        end
        CAP_DATA: data_q <= read_data_i;
        STREAM: begin
          if (ready_i && !is_last)
            idx_q <= idx_q + 16'd1;
        end
        ACK:  hold_q <= 1'b0;
        HOLD: hold_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_rx_drain_master.sv
// Bench for ethernet_rx_drain_master: controller model,
// scoreboard queue of expected stream words, directed steps.
module tb_ethernet_rx_drain_master;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [13:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i = '0;
  logic        rx_interrupt_pending_i = 1'b0;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_i = 1'b0;
  logic        last_o;
  logic [2:0]  last_bytes_o;
  logic        drop_o;
  logic        busy_o;

  ethernet_rx_drain_master dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .addr_o(addr_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
    .op_size_o(op_size_o), .write_data_o(write_data_o),
    .read_data_i(read_data_i),
    .rx_interrupt_pending_i(rx_interrupt_pending_i),
    .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .last_o(last_o),
    .last_bytes_o(last_bytes_o), .drop_o(drop_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [2:0]  lb;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int ack_count = 0;
  int drop_count = 0;
  int pop_count = 0;
  int read_count = 0;
  int rd_after_rst = 0;
  logic [13:0] first_rd = '1;
  int frame_size = 0;

  function automatic logic [31:0] pat(input logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // controller register file: sync read, size reg has junk above bit 15
  always @(posedge clk_i) begin
    if (read_en_o)
      read_data_i <= (addr_o == 14'h0) ? {16'hBEEF, 16'(frame_size)}
                                       : pat(addr_o);
    else
      read_data_i <= '0;
  end

  logic        prev_v = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_last = 1'b0;
  logic [2:0]  prev_lb = '0;

  // bus/stream monitor and scoreboard pop
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      prev_v = 1'b0;
      rd_after_rst = 0;
    end else begin
      chk("rd_wr_both", {63'd0, read_en_o & write_en_o}, 64'd0);
      if (!read_en_o && !write_en_o) begin
        chk("idle_addr", {50'd0, addr_o}, 64'd0);
        chk("idle_wdata", {32'd0, write_data_o}, 64'd0);
      end
      if (read_en_o) begin
        read_count++;
        if (rd_after_rst == 0) first_rd = addr_o;
        rd_after_rst++;
      end
      if (write_en_o) begin
        chk("ack_write", {18'd0, addr_o, write_data_o},
            {18'd0, 14'h4, 32'd1});
        ack_count++;
      end
      if (drop_o) drop_count++;
      if (v_o && prev_v && !prev_hs) begin
        chk("stall_data", {32'd0, data_o}, {32'd0, prev_d});
        chk("stall_last", {63'd0, last_o}, {63'd0, prev_last});
        chk("stall_lb", {61'd0, last_bytes_o}, {61'd0, prev_lb});
      end
      if (v_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {32'd0, data_o}, 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", {32'd0, data_o}, {32'd0, e.d});
          chk("word_last", {63'd0, last_o}, {63'd0, e.last});
          chk("word_lb", {61'd0, last_bytes_o}, {61'd0, e.lb});
        end
        pop_count++;
      end
      prev_v    = v_o;
      prev_hs   = v_o & ready_i;
      prev_d    = data_o;
      prev_last = last_o;
      prev_lb   = last_bytes_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int nwords(input int size);
    if (size == 0 || size > 1522) return 0;
    return (size + 3) / 4;
  endfunction

  task automatic push_frame(input int size);
    int w;
    w = nwords(size);
    frame_size = size;
    for (int i = 0; i < w; i++) begin
      exp_t e;
      e.d    = pat(14'(14'h1000 + 4 * i));
      e.last = (i == w - 1);
      e.lb   = (i != w - 1) ? 3'd4
             : (size % 4 == 0) ? 3'd4 : 3'(size % 4);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until_pops(input int target, input string tag);
    int n = 0;
    while (pop_count < target && n < 4000) begin
      step();
      n++;
    end
    chk(tag, 64'(pop_count), 64'(target));
  endtask

  task automatic wait_ack(input int target, input string tag);
    int n = 0;
    while (ack_count < target && n < 6000) begin
      step();
      n++;
    end
    chk(tag, 64'(ack_count), 64'(target));
  endtask

  // waits for ack, checks busy timing, word and drop totals
  task automatic finish_frame(input string tag, input int a0,
                              input int p0, input int d0,
                              input int words, input int drops);
    wait_ack(a0 + 1, {tag, "_ack"});
    rx_interrupt_pending_i = 1'b0;
    step();
    chk({tag, "_busy_hold"}, {63'd0, busy_o}, 64'd1);
    step();
    chk({tag, "_busy_idle"}, {63'd0, busy_o}, 64'd0);
    repeat (4) step();
    chk({tag, "_one_ack"}, 64'(ack_count), 64'(a0 + 1));
    chk({tag, "_words"}, 64'(pop_count - p0), 64'(words));
    chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count - d0), 64'(drops));
  endtask

  task automatic run_frame(input string tag, input int size);
    int a0, p0, d0;
    a0 = ack_count;
    p0 = pop_count;
    d0 = drop_count;
    push_frame(size);
    rx_interrupt_pending_i = 1'b1;
    finish_frame(tag, a0, p0, d0, nwords(size),
                 (nwords(size) == 0) ? 1 : 0);
  endtask

  initial begin
    int a0, p0, d0, r0, n;

    #2;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_v", {63'd0, v_o}, 64'd0);
    chk("rst_strobes", {62'd0, read_en_o, write_en_o}, 64'd0);
    chk("rst_data", {32'd0, data_o}, 64'd0);
    chk("rst_last", {60'd0, last_o, last_bytes_o}, 64'd0);
    repeat (2) step();
    reset_n_i = 1'b1;
    ready_i   = 1'b1;
    step();
    chk("op_size", {62'd0, op_size_o}, 64'd2);

    // disabled: pending must not start anything
    rx_interrupt_pending_i = 1'b1;
    frame_size = 60;
    r0 = read_count;
    a0 = ack_count;
    repeat (20) step();
    chk("dis_reads", 64'(read_count - r0), 64'd0);
    chk("dis_acks", 64'(ack_count - a0), 64'd0);
    chk("dis_busy", {63'd0, busy_o}, 64'd0);
    rx_interrupt_pending_i = 1'b0;
    enable_i = 1'b1;

    run_frame("f60", 60);
    run_frame("f61", 61);
    run_frame("f22", 22);
    run_frame("sz0", 0);
    run_frame("sz2000", 2000);
    run_frame("sz1523", 1523);
    run_frame("sz1522", 1522);

    // word 3 stalled for 10 cycles
    a0 = ack_count;
    p0 = pop_count;
    d0 = drop_count;
    push_frame(20);
    rx_interrupt_pending_i = 1'b1;
    wait_until_pops(p0 + 2, "stall_reach");
    ready_i = 1'b0;
    n = 0;
    while (!v_o && n < 50) begin
      step();
      n++;
    end
    r0 = read_count;
    repeat (10) step();
    chk("stall_v", {63'd0, v_o}, 64'd1);
    chk("stall_no_read", 64'(read_count - r0), 64'd0);
    ready_i = 1'b1;
    finish_frame("stall", a0, p0, d0, 5, 0);

    // enable and pending dropped mid-frame: frame still completes
    a0 = ack_count;
    p0 = pop_count;
    d0 = drop_count;
    push_frame(33);
    rx_interrupt_pending_i = 1'b1;
    wait_until_pops(p0 + 2, "mid_reach");
    enable_i = 1'b0;
    rx_interrupt_pending_i = 1'b0;
    finish_frame("mid", a0, p0, d0, 9, 0);
    enable_i = 1'b1;

    // async reset during word 7
    a0 = ack_count;
    p0 = pop_count;
    push_frame(60);
    rx_interrupt_pending_i = 1'b1;
    wait_until_pops(p0 + 6, "rst_reach");
    ready_i = 1'b0;
    n = 0;
    while (!v_o && n < 50) begin
      step();
      n++;
    end
    #1 reset_n_i = 1'b0;
    #1;
    chk("mrst_v", {63'd0, v_o}, 64'd0);
    chk("mrst_busy", {63'd0, busy_o}, 64'd0);
    chk("mrst_data", {32'd0, data_o}, 64'd0);
    chk("mrst_last", {60'd0, last_o, last_bytes_o}, 64'd0);
    chk("mrst_strobes", {61'd0, read_en_o, write_en_o, drop_o},
        64'd0);
    chk("mrst_bus", {18'd0, addr_o, write_data_o}, 64'd0);
    exp_q.delete();
    repeat (2) step();
    reset_n_i = 1'b1;
    ready_i   = 1'b1;
    chk("mrst_no_ack", 64'(ack_count), 64'(a0));
    p0 = pop_count;
    d0 = drop_count;
    push_frame(60);
    finish_frame("post_rst", a0, p0, d0, 15, 0);
    chk("post_rst_first_rd", {50'd0, first_rd}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
